// File: rtl/special_result_generator_if.sv
// Operand/result handshake bundle for the FMA special-result generator.
// The master drives operands and downstream ready; the slave returns results.
interface special_result_generator_if #(
  parameter int PARM_XLEN = 32
);
  logic                 Valid_i;
  logic                 Ready_o;
  logic [PARM_XLEN-1:0] A_i;
  logic [PARM_XLEN-1:0] B_i;
  logic [PARM_XLEN-1:0] C_i;
  logic [2:0]           A_Flags_i;
  logic [2:0]           B_Flags_i;
  logic [2:0]           C_Flags_i;
  logic [2:0]           Rm_i;
  logic                 Valid_o;
  logic                 Ready_i;
  logic                 Special_o;
  logic [PARM_XLEN-1:0] Result_o;
  logic                 NV_o;

  modport master (
    output Valid_i, A_i, B_i, C_i, A_Flags_i, B_Flags_i, C_Flags_i, Rm_i, Ready_i,
    input  Ready_o, Valid_o, Special_o, Result_o, NV_o
  );

  modport slave (
    input  Valid_i, A_i, B_i, C_i, A_Flags_i, B_Flags_i, C_Flags_i, Rm_i, Ready_i,
    output Ready_o, Valid_o, Special_o, Result_o, NV_o
  );
endinterface

// File: rtl/special_result_generator.sv
// Two-stage pipeline that resolves NaN/Inf/Zero special cases of R = A*B + C
// and keeps a sticky invalid-operation flag.
module special_result_generator #(
  parameter int PARM_XLEN = 32,
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  special_result_generator_if.slave  bus,
  input  logic                       FlagClear_i,
  output logic                       NV_Sticky_o
);
  localparam int SIGN = PARM_XLEN - 1;
  localparam int QBIT = PARM_MANT - 1;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [PARM_XLEN-1:0] CANON_NAN =
    {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [PARM_XLEN-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]           a_flags_q, a_flags_d, b_flags_q, b_flags_d, c_flags_q, c_flags_d;
  logic [2:0]           rm_q, rm_d;
  logic                 special_q, special_d, nv_q, nv_d, sticky_q, sticky_d;
  logic [PARM_XLEN-1:0] result_q, result_d;

  logic s1_load, s2_load;
  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, c_nan, c_inf, c_zero;
  logic any_snan, any_nan, sp, sc, p_inf, p_zero, invalid;
  logic special_calc, nv_calc;
  logic [PARM_XLEN-1:0] result_calc;
  logic unused_bits;

  // A full pipeline can still advance when the consumer takes the head.
  assign s2_load     = ~v2_q | bus.Ready_i;
  assign s1_load     = ~v1_q | s2_load;
  assign bus.Ready_o = s1_load;

  assign {a_nan, a_inf, a_zero} = a_flags_q;
  assign {b_nan, b_inf, b_zero} = b_flags_q;
  assign {c_nan, c_inf, c_zero} = c_flags_q;

  assign any_snan = (a_nan & ~a_q[QBIT]) | (b_nan & ~b_q[QBIT]) | (c_nan & ~c_q[QBIT]);
  assign any_nan  = a_nan | b_nan | c_nan;
  assign sp       = a_q[SIGN] ^ b_q[SIGN];
  assign sc       = c_q[SIGN];
  assign p_inf    = (a_inf | b_inf) & ~(a_zero | b_zero);
  assign p_zero   = (a_zero | b_zero) & ~(a_inf | b_inf);
  assign invalid  = any_snan | ((a_inf | b_inf) & (a_zero | b_zero)) | (p_inf & c_inf & (sp != sc));

  // Only sign and quiet bit of each operand take part in classification.
  assign unused_bits = ^{a_q[PARM_XLEN-2:PARM_MANT], a_q[PARM_MANT-2:0],
                         b_q[PARM_XLEN-2:PARM_MANT], b_q[PARM_MANT-2:0],
                         c_q[PARM_XLEN-2:PARM_MANT], c_q[PARM_MANT-2:0]};

  always_comb begin
    special_calc = 1'b0;
    result_calc  = '0;
    nv_calc      = 1'b0;
    if (invalid) begin
      special_calc = 1'b1;
      result_calc  = CANON_NAN;
      nv_calc      = 1'b1;
    end else if (any_nan) begin
      special_calc = 1'b1;
      result_calc  = CANON_NAN;
    end else if (p_inf) begin
      special_calc = 1'b1;
      result_calc  = {sp, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
    end else if (c_inf) begin
      special_calc = 1'b1;
      result_calc  = {sc, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
    end else if (p_zero & c_zero) begin
      special_calc = 1'b1;
      result_calc  = {((sp == sc) ? sp : (rm_q == RM_RDN)), {(PARM_XLEN-1){1'b0}}};
    end
  end

  always_comb begin
    v1_d      = v1_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    a_flags_d = a_flags_q;
    b_flags_d = b_flags_q;
    c_flags_d = c_flags_q;
    rm_d      = rm_q;
    v2_d      = v2_q;
    special_d = special_q;
    result_d  = result_q;
    nv_d      = nv_q;
    sticky_d  = sticky_q;

    if (s1_load) begin
      v1_d      = bus.Valid_i;
      a_d       = bus.A_i;
      b_d       = bus.B_i;
      c_d       = bus.C_i;
      a_flags_d = bus.A_Flags_i;
      b_flags_d = bus.B_Flags_i;
      c_flags_d = bus.C_Flags_i;
      rm_d      = bus.Rm_i;
    end

    // A bubble moving into S2 leaves all-zero outputs behind.
    if (s2_load) begin
      v2_d      = v1_q;
      special_d = v1_q & special_calc;
      result_d  = v1_q ? result_calc : '0;
      nv_d      = v1_q & nv_calc;
    end

    if (FlagClear_i)
      sticky_d = 1'b0;
    if (v2_q & bus.Ready_i & nv_q)
      sticky_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
      nv_q      <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      special_q <= special_d;
      result_q  <= result_d;
      nv_q      <= nv_d;
      sticky_q  <= sticky_d;
    end
  end

  always_ff @(posedge clk_i) begin
    a_q       <= a_d;
    b_q       <= b_d;
    c_q       <= c_d;
    a_flags_q <= a_flags_d;
    b_flags_q <= b_flags_d;
    c_flags_q <= c_flags_d;
    rm_q      <= rm_d;
  end

  assign bus.Valid_o   = v2_q;
  assign bus.Special_o = special_q;
  assign bus.Result_o  = result_q;
  assign bus.NV_o      = nv_q;
  assign NV_Sticky_o   = sticky_q;
endmodule

// File: tb/tb_special_result_generator.sv
// Self-checking bench: directed vector table, stall/reset sequences and
// randomized traffic against an in-order scoreboard of rule-derived results.
module tb_special_result_generator;
  typedef struct packed {
    logic        special;
    logic [31:0] result;
    logic        nv;
  } res_t;

  typedef struct {
    logic [31:0] a, b, c;
    logic [2:0]  af, bf, cf, rm;
    res_t        exp;
  } vec_t;

  typedef struct {
    res_t r;
    int   acc_cycle;
  } inflight_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag_clear = 1'b0;
  logic nv_sticky;

  always #5 clk = ~clk;

  special_result_generator_if #(.PARM_XLEN(32)) bus ();

  special_result_generator #(
    .PARM_XLEN(32),
    .PARM_EXP (8),
    .PARM_MANT(23)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .FlagClear_i(flag_clear),
    .NV_Sticky_o(nv_sticky)
  );

  int        vectors = 0;
  int        miscompares = 0;
  int        cycle = 0;
  int        xfers = 0;
  logic      exp_sticky = 1'b0;
  inflight_t sb[$];
  vec_t      tbl[15];
  vec_t      idle_vec;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  // Reference: IEEE-754 FMA special-case rules, evaluated top-down.
  function automatic res_t ref_model(input vec_t x);
    res_t r;
    bit an = x.af[2], ai = x.af[1], az = x.af[0];
    bit bn = x.bf[2], bi = x.bf[1], bz = x.bf[0];
    bit cn = x.cf[2], ci = x.cf[1], cz = x.cf[0];
    bit signaling = (an && !x.a[22]) || (bn && !x.b[22]) || (cn && !x.c[22]);
    bit sp = x.a[31] ^ x.b[31];
    bit sc = x.c[31];
    bit prod_inf  = (ai || bi) && !(az || bz);
    bit prod_zero = (az || bz) && !(ai || bi);
    if (signaling || ((ai || bi) && (az || bz)) || (prod_inf && ci && sp != sc)) begin
      r = '{1'b1, QNAN, 1'b1}; return r;
    end
    if (an || bn || cn) begin r = '{1'b1, QNAN, 1'b0}; return r; end
    if (prod_inf) begin r = '{1'b1, {sp, 8'hFF, 23'h0}, 1'b0}; return r; end
    if (ci) begin r = '{1'b1, {sc, 8'hFF, 23'h0}, 1'b0}; return r; end
    if (prod_zero && cz) begin
      if (sp == sc) r = '{1'b1, {sp, 31'h0}, 1'b0};
      else          r = '{1'b1, {(x.rm == 3'b010), 31'h0}, 1'b0};
      return r;
    end
    r = '{1'b0, 32'h0, 1'b0};
    return r;
  endfunction

  task automatic gen_op(output logic [31:0] v, output logic [2:0] f);
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: begin v = {s, 31'h0};                                      f = 3'b001; end
      1: begin v = {s, 8'hFF, 23'h0};                               f = 3'b010; end
      2: begin v = {s, 8'hFF, 1'b1, 22'($urandom)};                 f = 3'b100; end
      3: begin v = {s, 8'hFF, 1'b0, 22'($urandom_range(1, 4194303))}; f = 3'b100; end
      default: begin v = {s, 8'($urandom_range(1, 254)), 23'($urandom)}; f = 3'b000; end
    endcase
  endtask

  // One clock of traffic: drive at negedge, check and update the model before posedge.
  task automatic step(input logic v, input vec_t x, input logic rdy, input logic clr);
    logic exp_valid;
    logic set_nv;
    inflight_t e;
    @(negedge clk);
    bus.Valid_i = v;   bus.A_i = x.a;  bus.B_i = x.b;  bus.C_i = x.c;
    bus.A_Flags_i = x.af; bus.B_Flags_i = x.bf; bus.C_Flags_i = x.cf; bus.Rm_i = x.rm;
    bus.Ready_i = rdy; flag_clear = clr;
    #1;
    exp_valid = 1'b0;
    if (sb.size() > 0) exp_valid = (cycle - sb[0].acc_cycle) >= 2;
    check("ready_o", 64'(bus.Ready_o), 64'((sb.size() < 2) || rdy));
    check("valid_o", 64'(bus.Valid_o), 64'(exp_valid));
    check("nv_sticky", 64'(nv_sticky), 64'(exp_sticky));
    set_nv = 1'b0;
    if (exp_valid) begin
      check("result", 64'({bus.Special_o, bus.Result_o, bus.NV_o}), 64'(sb[0].r));
      if (rdy) begin
        e = sb.pop_front();
        set_nv = e.r.nv;
        xfers++;
        $display("xfer %0d: special=%b result=%h nv=%b", xfers, e.r.special, e.r.result, e.r.nv);
      end
    end
    if (v && ((sb.size() < 2) || rdy)) begin
      e.r = x.exp;
      e.acc_cycle = cycle;
      sb.push_back(e);
    end
    if (set_nv) exp_sticky = 1'b1;
    else if (clr) exp_sticky = 1'b0;
    cycle++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; bus.Valid_i = 1'b0; bus.Ready_i = 1'b0; flag_clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_sticky = 1'b0;
    cycle += 2;
    #1;
    check("rst_valid_o", 64'(bus.Valid_o), 64'h0);
    check("rst_outputs", 64'({bus.Special_o, bus.Result_o, bus.NV_o}), 64'h0);
    check("rst_sticky", 64'(nv_sticky), 64'h0);
    check("rst_ready_o", 64'(bus.Ready_o), 64'h1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      step(1'b0, idle_vec, 1'b1, 1'b0);
      budget++;
    end
    check("drain_empty", 64'(sb.size()), 64'h0);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [2:0] af, input logic [31:0] b,
                              input logic [2:0] bf, input logic [31:0] c, input logic [2:0] cf,
                              input logic [2:0] rm, input logic sp, input logic [31:0] res,
                              input logic nv);
    vec_t t;
    t.a = a; t.af = af; t.b = b; t.bf = bf; t.c = c; t.cf = cf; t.rm = rm;
    t.exp = '{sp, res, nv};
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t x;
    int   k;
    idle_vec = mk(32'h0, 3'b000, 32'h0, 3'b000, 32'h0, 3'b000, 3'b000, 1'b0, 32'h0, 1'b0);
    bus.Valid_i = 1'b0; bus.Ready_i = 1'b0;
    bus.A_i = '0; bus.B_i = '0; bus.C_i = '0;
    bus.A_Flags_i = '0; bus.B_Flags_i = '0; bus.C_Flags_i = '0; bus.Rm_i = '0;

    //            A            Af      B            Bf      C            Cf      Rm      Sp    Result        NV
    tbl[0]  = mk(32'h7F800000, 3'b010, 32'h00000000, 3'b001, 32'h3F800000, 3'b000, 3'b000, 1'b1, 32'h7FC00000, 1'b1);
    tbl[1]  = mk(32'h7F800000, 3'b010, 32'h3F800000, 3'b000, 32'hFF800000, 3'b010, 3'b000, 1'b1, 32'h7FC00000, 1'b1);
    tbl[2]  = mk(32'h7F800000, 3'b010, 32'h3F800000, 3'b000, 32'h7F800000, 3'b010, 3'b000, 1'b1, 32'h7F800000, 1'b0);
    tbl[3]  = mk(32'h00000000, 3'b001, 32'h3F800000, 3'b000, 32'h80000000, 3'b001, 3'b000, 1'b1, 32'h00000000, 1'b0);
    tbl[4]  = mk(32'h00000000, 3'b001, 32'h3F800000, 3'b000, 32'h80000000, 3'b001, 3'b010, 1'b1, 32'h80000000, 1'b0);
    tbl[5]  = mk(32'h7FA00000, 3'b100, 32'h3F800000, 3'b000, 32'h3F800000, 3'b000, 3'b000, 1'b1, 32'h7FC00000, 1'b1);
    tbl[6]  = mk(32'h7FC00001, 3'b100, 32'h3F800000, 3'b000, 32'h3F800000, 3'b000, 3'b000, 1'b1, 32'h7FC00000, 1'b0);
    tbl[7]  = mk(32'h3F800000, 3'b000, 32'h40000000, 3'b000, 32'h3F800000, 3'b000, 3'b000, 1'b0, 32'h00000000, 1'b0);
    tbl[8]  = mk(32'hFF800000, 3'b010, 32'h40000000, 3'b000, 32'h3F800000, 3'b000, 3'b000, 1'b1, 32'hFF800000, 1'b0);
    tbl[9]  = mk(32'h3F800000, 3'b000, 32'h3F800000, 3'b000, 32'hFF800000, 3'b010, 3'b000, 1'b1, 32'hFF800000, 1'b0);
    tbl[10] = mk(32'h80000000, 3'b001, 32'h3F800000, 3'b000, 32'h80000000, 3'b001, 3'b000, 1'b1, 32'h80000000, 1'b0);
    tbl[11] = mk(32'h7F800000, 3'b010, 32'h00000000, 3'b001, 32'h7FC00000, 3'b100, 3'b000, 1'b1, 32'h7FC00000, 1'b1);
    tbl[12] = mk(32'h3F800000, 3'b000, 32'h3F800000, 3'b000, 32'h7F800001, 3'b100, 3'b000, 1'b1, 32'h7FC00000, 1'b1);
    tbl[13] = mk(32'h00000000, 3'b001, 32'h3F800000, 3'b000, 32'hFF800000, 3'b010, 3'b000, 1'b1, 32'hFF800000, 1'b0);
    tbl[14] = mk(32'h00000000, 3'b001, 32'h3F800000, 3'b000, 32'h3F800000, 3'b000, 3'b010, 1'b0, 32'h00000000, 1'b0);

    apply_reset();

    // Isolated transaction: 2-cycle latency, then sticky NV set.
    step(1'b1, tbl[0], 1'b1, 1'b0);
    step(1'b0, idle_vec, 1'b1, 1'b0);
    step(1'b0, idle_vec, 1'b1, 1'b0);
    step(1'b0, idle_vec, 1'b1, 1'b0);

    // Full table back-to-back at full throughput.
    for (int i = 0; i < 15; i++) step(1'b1, tbl[i], 1'b1, 1'b0);
    drain();

    // Four triples offered back-to-back with the consumer stalled for three cycles.
    k = 0;
    for (int c = 0; c < 12 && (k < 4 || sb.size() > 0); c++) begin
      logic rdy;
      logic acc;
      rdy = (c >= 3);
      acc = (k < 4) && ((sb.size() < 2) || rdy);
      if (k < 4) step(1'b1, tbl[(k * 3 + 1) % 15], rdy, 1'b0);
      else       step(1'b0, idle_vec, rdy, 1'b0);
      if (acc) k++;
    end
    check("stall_all_accepted", 64'(k), 64'd4);
    drain();

    // NV transfer and clear together: the set wins; a lone clear then clears.
    step(1'b0, idle_vec, 1'b1, 1'b1);
    step(1'b1, tbl[5], 1'b1, 1'b0);
    step(1'b0, idle_vec, 1'b1, 1'b0);
    step(1'b0, idle_vec, 1'b1, 1'b1);
    step(1'b0, idle_vec, 1'b1, 1'b1);
    step(1'b0, idle_vec, 1'b1, 1'b0);

    // Fill both stages under stall, then reset: nothing may come out.
    step(1'b1, tbl[0], 1'b0, 1'b0);
    step(1'b1, tbl[1], 1'b0, 1'b0);
    step(1'b0, idle_vec, 1'b0, 1'b0);
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, idle_vec, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic v, rdy, clr;
      gen_op(x.a, x.af);
      gen_op(x.b, x.bf);
      gen_op(x.c, x.cf);
      x.rm  = 3'($urandom_range(0, 7));
      x.exp = ref_model(x);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      step(v, x, rdy, clr);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
